// File: rtl/if_id_queue.sv
// IF->ID decoupling stage: an output register fed by a small in-order queue.
// Fetch keeps delivering while decode stalls. The output register always
// holds an instruction older than anything still waiting in the queue.
module if_id_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  if_valid_in,
    input  logic [ADDR_WIDTH-1:0] if_pc_in,
    input  logic [INST_WIDTH-1:0] if_inst_in,
    output logic                  if_ready_out,
    input  logic                  id_stall_in,
    output logic                  id_valid_out,
    output logic [ADDR_WIDTH-1:0] id_pc_out,
    output logic [INST_WIDTH-1:0] id_inst_out,
    output logic [PTR_WIDTH:0]    count_out
);

    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic [PTR_WIDTH-1:0]  head;
    logic [PTR_WIDTH-1:0]  tail;

    logic adv;
    logic push;
    logic empty;
    logic wr_en;

    // Readiness comes only from the registered count, so decode stall never
    // reaches fetch combinationally; a full queue refuses even if it pops.
    assign if_ready_out = (count_out < (PTR_WIDTH+1)'(DEPTH));
    assign adv          = !id_valid_out || !id_stall_in;
    assign push         = if_valid_in && if_ready_out;
    assign empty        = (count_out == '0);
    // A fetch is written into the queue unless it bypasses straight to the
    // output (empty queue, output advancing) or is killed by flush.
    assign wr_en        = rdy_in && !rst_in && !flush_in && push && !(adv && empty);

    // Queue storage: no reset needed, contents are only read when counted.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            pc_mem[tail]   <= if_pc_in;
            inst_mem[tail] <= if_inst_in;
        end
    end

    // Pointer, occupancy and output register update in flush/advance priority.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head         <= '0;
            tail         <= '0;
            count_out    <= '0;
            id_valid_out <= 1'b0;
            id_pc_out    <= '0;
            id_inst_out  <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head         <= '0;
                tail         <= '0;
                count_out    <= '0;
                id_valid_out <= 1'b0;
                id_pc_out    <= '0;
                id_inst_out  <= '0;
            end else if (adv && !empty) begin
                id_valid_out <= 1'b1;
                id_pc_out    <= pc_mem[head];
                id_inst_out  <= inst_mem[head];
                head         <= head + PTR_WIDTH'(1);
                if (push) begin
                    tail <= tail + PTR_WIDTH'(1);
                end else begin
                    count_out <= count_out - (PTR_WIDTH+1)'(1);
                end
            end else if (adv && push) begin
                id_valid_out <= 1'b1;
                id_pc_out    <= if_pc_in;
                id_inst_out  <= if_inst_in;
            end else if (adv) begin
                id_valid_out <= 1'b0;
                id_pc_out    <= '0;
                id_inst_out  <= '0;
            end else if (push) begin
                tail      <= tail + PTR_WIDTH'(1);
                count_out <= count_out + (PTR_WIDTH+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue with a small queue model
// used for the pointer-wrap sequence.
module tb_if_id_queue;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        if_valid_in;
    logic [31:0] if_pc_in;
    logic [31:0] if_inst_in;
    logic        if_ready_out;
    logic        id_stall_in;
    logic        id_valid_out;
    logic [31:0] id_pc_out;
    logic [31:0] id_inst_out;
    logic [2:0]  count_out;

    int vectors;
    int miscompares;

    logic [31:0] model_q[$];
    logic        m_valid;
    logic [31:0] m_pc;

    if_id_queue #(
        .ADDR_WIDTH(32),
        .INST_WIDTH(32),
        .DEPTH(4),
        .PTR_WIDTH(2)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .flush_in    (flush_in),
        .if_valid_in (if_valid_in),
        .if_pc_in    (if_pc_in),
        .if_inst_in  (if_inst_in),
        .if_ready_out(if_ready_out),
        .id_stall_in (id_stall_in),
        .id_valid_out(id_valid_out),
        .id_pc_out   (id_pc_out),
        .id_inst_out (id_inst_out),
        .count_out   (count_out)
    );

    // Free-running clock, rising edge active.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                                 input logic stall, input logic flush,
                                 input logic rdy);
        if_valid_in = valid;
        if_pc_in    = pc;
        if_inst_in  = inst_of(pc);
        id_stall_in = stall;
        flush_in    = flush;
        rdy_in      = rdy;
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOut(input string tag, input logic valid,
                            input logic [31:0] pc, input int cnt);
        checkOutput({tag, ".valid"}, 64'(id_valid_out), 64'(valid));
        checkOutput({tag, ".pc"}, 64'(id_pc_out), 64'(pc));
        checkOutput({tag, ".inst"}, 64'(id_inst_out), valid ? 64'(inst_of(pc)) : 64'd0);
        checkOutput({tag, ".count"}, 64'(count_out), 64'(cnt));
    endtask

    // Model step mirroring the behavioural rules, using an unbounded queue.
    task automatic modelStep(input logic valid, input logic [31:0] pc, input logic stall);
        logic adv;
        logic push;
        adv  = !m_valid || !stall;
        push = valid && (model_q.size() < 4);
        if (adv && model_q.size() > 0) begin
            m_pc    = model_q.pop_front();
            m_valid = 1'b1;
            if (push) model_q.push_back(pc);
        end else if (adv && push) begin
            m_pc    = pc;
            m_valid = 1'b1;
        end else if (adv) begin
            m_pc    = '0;
            m_valid = 1'b0;
        end else if (push) begin
            model_q.push_back(pc);
        end
    endtask

    task automatic modelCycle(input string tag, input logic valid,
                              input logic [31:0] pc, input logic stall);
        checkOutput({tag, ".ready"}, 64'(if_ready_out), 64'(model_q.size() < 4));
        modelStep(valid, pc, stall);
        applyStimulus(valid, pc, stall, 1'b0, 1'b1);
        checkOut(tag, m_valid, m_pc, model_q.size());
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_in      = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        rst_in = 1'b0;
        checkOut("reset", 1'b0, 32'h0, 0);
        checkOutput("reset.ready", 64'(if_ready_out), 64'd1);

        // Pass-through with one-cycle latency.
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOut("pass0", 1'b1, 32'h0, 0);
        applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 1'b1);
        checkOut("pass4", 1'b1, 32'h4, 0);
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 1'b1);
        checkOut("pass8", 1'b1, 32'h8, 0);

        // Fill the queue behind a stalled output.
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOut("fill.head", 1'b1, 32'h0, 0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b1);
            checkOut($sformatf("fill%0d", i), 1'b1, 32'h0, i);
        end
        checkOutput("full.ready", 64'(if_ready_out), 64'd0);
        applyStimulus(1'b1, 32'h14, 1'b1, 1'b0, 1'b1);
        checkOut("full.ignored", 1'b1, 32'h0, 4);
        // Pop while full: the concurrent push is still refused.
        applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 1'b1);
        checkOut("drain4", 1'b1, 32'h4, 3);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOut("drain8", 1'b1, 32'h8, 2);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOut("drainC", 1'b1, 32'hC, 1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOut("drain10", 1'b1, 32'h10, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOut("drain.bubble", 1'b0, 32'h0, 0);

        // Steady state with two queued entries and a push every cycle.
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h24, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h28, 1'b1, 1'b0, 1'b1);
        checkOut("steady.setup", 1'b1, 32'h20, 2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'(32'h2C + i * 4), 1'b0, 1'b0, 1'b1);
            checkOut($sformatf("steady%0d", i), 1'b1, 32'(32'h24 + i * 4), 2);
        end

        // Flush with three queued entries and a simultaneous push.
        applyStimulus(1'b1, 32'h3C, 1'b1, 1'b0, 1'b1);
        checkOut("flush.setup", 1'b1, 32'h30, 3);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b1, 1'b1);
        checkOut("flush", 1'b0, 32'h0, 0);
        checkOutput("flush.ready", 64'(if_ready_out), 64'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOut("flush.after", 1'b0, 32'h0, 0);

        // Global enable low freezes everything, including flush.
        applyStimulus(1'b1, 32'h50, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h54, 1'b1, 1'b0, 1'b1);
        checkOut("rdy.setup", 1'b1, 32'h50, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'(32'h58 + i * 4), 1'b0, (i == 1), 1'b0);
            checkOut($sformatf("rdy.hold%0d", i), 1'b1, 32'h50, 1);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOut("rdy.resume", 1'b1, 32'h54, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOut("rdy.bubble", 1'b0, 32'h0, 0);

        // Pointer wrap against the queue model, stall toggling every 2 cycles.
        m_valid = 1'b0;
        m_pc    = '0;
        model_q.delete();
        for (int i = 0; i < 10; i++) begin
            modelCycle($sformatf("wrap%0d", i), 1'b1, 32'(32'h100 + i * 4),
                       logic'((i / 2) % 2));
        end
        for (int i = 0; i < 6; i++) begin
            modelCycle($sformatf("wrap.drain%0d", i), 1'b0, 32'h0, 1'b0);
        end

        // Reset in the middle of a stall drops everything in flight.
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h204, 1'b1, 1'b0, 1'b1);
        checkOut("rst.setup", 1'b1, 32'h200, 1);
        rst_in = 1'b1;
        applyStimulus(1'b1, 32'h208, 1'b1, 1'b0, 1'b0);
        rst_in = 1'b0;
        checkOut("rst.mid", 1'b0, 32'h0, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOut("rst.after", 1'b0, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF→ID decoupling stage between the fetch unit and the decoder. It replaces the single IF/ID pipeline register with an output register plus a small in-order instruction queue. Fetch can keep delivering while decode is stalled, and nothing is lost or duplicated. Flush (branch taken / mispredict from EX) and global `rdy_in` gating behave as in the rest of the pipeline.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, PC width.
- `INST_WIDTH`, 32, instruction width.
- `DEPTH`, 4, queue entries; power of two, ≥2.
- `PTR_WIDTH`, 2, log2(DEPTH).

Ports:
- `clk_in`  in  1  single clock, all state updates on rising edge.
- `rst_in`  in  1  reset, synchronous, active-high.
- `rdy_in`  in  1  global enable; low = every register holds.
- `flush_in`  in  1  branch/mispredict flush from EX.
- `if_valid_in`  in  1  fetch presents a valid instruction this cycle.
- `if_pc_in`  in  ADDR_WIDTH  PC of fetched instruction.
- `if_inst_in`  in  INST_WIDTH  fetched instruction.
- `if_ready_out`  out  1  stage can accept from fetch; combinational, = (`count_out` < DEPTH).
- `id_stall_in`  in  1  decode cannot consume the current output this cycle.
- `id_valid_out`  out  1  output register holds a valid instruction.
- `id_pc_out`  out  ADDR_WIDTH  PC to decode.
- `id_inst_out`  out  INST_WIDTH  instruction to decode; 0 = bubble.
- `count_out`  out  PTR_WIDTH+1  queue occupancy 0..DEPTH (excludes output register).

## Operation
- Storage: DEPTH-entry circular buffer of {pc, inst}. `head` and `tail` pointers are PTR_WIDTH wide and wrap modulo DEPTH. Occupancy is a separate counter of width PTR_WIDTH+1.
- Output advance condition `adv` = !`id_valid_out` || !`id_stall_in`.
- Accepted fetch `push` = `if_valid_in` && `if_ready_out`.
- Per edge, with `rdy_in`=1 and `rst_in`=0, evaluated in priority order:
  1. `flush_in`=1: head=tail=count=0, `id_valid_out`=0, `id_pc_out`=0, `id_inst_out`=0. A push in the same cycle is discarded.
  2. `adv` and queue non-empty: output ← entry[head], valid=1, head+1, count−1. If `push`, the new entry goes to entry[tail], tail+1, count+1, so count is net unchanged.
  3. `adv`, queue empty, `push`: bypass. Output ← {if_pc_in, if_inst_in}, valid=1. Queue untouched.
  4. `adv`, queue empty, no push: output ← bubble (valid=0, pc=0, inst=0).
  5. !`adv` (stalled with valid output): output holds. If `push`, write tail, tail+1, count+1.
- Ordering strictly preserved: the output register always holds an instruction older than every queued entry. The bypass in case 3 is allowed only when the queue is empty.
- Full (count=DEPTH): `if_ready_out`=0, even if a pop occurs the same cycle. No same-cycle push-on-full.
- `rdy_in`=0: no state changes, including flush. Outputs are held.
- `rst_in`=1 (overrides `rdy_in`): all pointers, counters and outputs = 0. Queue contents don't-care. Reset mid-stall drops all in-flight instructions.

## Timing
- Empty queue, decode free: fetch presented in cycle N is on `id_*_out` from cycle N+1 (1-cycle latency, same as a plain IF/ID register).
- Queued instruction: visible in the cycle after the first edge where `adv`=1.
- Flush asserted in cycle N: outputs are bubble from cycle N+1. `if_ready_out`=1 from cycle N+1.
- Throughput: one instruction per cycle sustained when `id_stall_in`=0.
- `if_ready_out` depends only on registered count, so there is no combinational path from `id_stall_in`.

## Test plan
- Reset → all outputs 0, `if_ready_out`=1, `count_out`=0. Then push pc=0x0,0x4,0x8 on consecutive cycles with no stall → `id_pc_out` shows 0x0,0x4,0x8 on cycles 1,2,3, count stays 0.
- Hold `id_stall_in`=1 with output pc=0x0 valid. Push 0x4..0x10 (4 entries) → count=4, `if_ready_out`=0, a 5th push is ignored. Release stall → outputs 0x4,0x8,0xC,0x10 on successive cycles, then bubble.
- Queue holding 2 entries, decode free, push every cycle → count stays 2, output order monotonic, no loss or duplicates.
- Flush with count=3 and a simultaneous push → next cycle valid=0, pc=0, inst=0, count=0. The pushed instruction never appears.
- `rdy_in`=0 for 3 cycles with stall released and pushes driven → outputs, count and pointers are unchanged.
- Tail wrap: run 10 push/pop cycles with DEPTH=4 and stall toggling every 2 cycles → output sequence equals input sequence, checked against a reference model.
